// File: rtl/mem_arbiter.sv
// Two-client round-robin line arbiter in front of the memory model.
// Read responses come back in order, so a FIFO of client tags routes each one.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          c0_req,
  input  logic                          c1_req,
  input  logic                          c0_we,
  input  logic                          c1_we,
  input  logic [ADDR_WIDTH-1:0]         c0_addr,
  input  logic [ADDR_WIDTH-1:0]         c1_addr,
  input  logic [LINE_BYTES*8-1:0]       c0_wdata,
  input  logic [LINE_BYTES*8-1:0]       c1_wdata,
  output logic                          c0_gnt,
  output logic                          c1_gnt,
  output logic                          c0_rvalid,
  output logic                          c1_rvalid,
  output logic [LINE_BYTES*8-1:0]       c0_rdata,
  output logic [LINE_BYTES*8-1:0]       c1_rdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [LINE_BYTES*8-1:0]       mem_wdata,
  input  logic                          mem_gnt,
  input  logic                          mem_rvalid,
  input  logic [LINE_BYTES*8-1:0]       mem_rdata,
  output logic [$clog2(TAG_DEPTH):0]    outstanding,
  output logic                          resp_err
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(TAG_DEPTH);

  logic          prio;
  logic          tag_mem [TAG_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic c0_elig, c1_elig, sel_valid, sel, sel_we;
  logic grant, push, pop, empty, head;

  // Reads need a free tag slot; writes never produce a response so never wait.
  always_comb begin
    empty     = (count == '0);
    c0_elig   = !rst && c0_req && (c0_we || (count < DEPTH));
    c1_elig   = !rst && c1_req && (c1_we || (count < DEPTH));
    sel_valid = c0_elig || c1_elig;
    sel       = (c0_elig && c1_elig) ? prio : c1_elig;
    sel_we    = sel ? c1_we : c0_we;
    grant     = sel_valid && mem_gnt;
    push      = grant && !sel_we;
    pop       = !rst && mem_rvalid && !empty;
    head      = tag_mem[rd_ptr];
  end

  assign mem_req     = sel_valid;
  assign mem_we      = sel_valid && sel_we;
  assign mem_addr    = !sel_valid ? '0 : (sel ? c1_addr : c0_addr);
  assign mem_wdata   = !sel_valid ? '0 : (sel ? c1_wdata : c0_wdata);
  assign c0_gnt      = grant && !sel;
  assign c1_gnt      = grant && sel;
  assign c0_rvalid   = pop && !head;
  assign c1_rvalid   = pop && head;
  assign c0_rdata    = mem_rdata;
  assign c1_rdata    = mem_rdata;
  assign outstanding = count;

  // A response with no tag in flight is dropped and flagged until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      resp_err <= 1'b0;
    end else begin
      if (grant) prio <= ~sel;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (mem_rvalid && empty) resp_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= sel;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of arbitration and routing.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam logic [DW-1:0] LINE_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic c0_req = 1'b0, c1_req = 1'b0, c0_we = 1'b0, c1_we = 1'b0;
  logic [AW-1:0] c0_addr = '0, c1_addr = '0;
  logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
  logic c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [4:0] outstanding;
  logic resp_err;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of client IDs awaiting a response, favoured client, error flag.
  int tag_q[$];
  int prio_m = 0;
  bit err_m = 1'b0;
  bit m_gnt0, m_gnt1;

  logic r0, w0, r1, w1, mg, mr, h0, h1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1, rd;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c1_req(c1_req), .c0_we(c0_we), .c1_we(c1_we),
    .c0_addr(c0_addr), .c1_addr(c1_addr), .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
    .c0_gnt(c0_gnt), .c1_gnt(c1_gnt), .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
    .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .outstanding(outstanding), .resp_err(resp_err)
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    tag_q.delete();
    prio_m = 0;
    err_m = 1'b0;
  endtask

  // Drive one cycle at the falling edge, compare against the model, then advance the model.
  task automatic applyStimulus(input logic ir0, input logic iw0, input logic [AW-1:0] ia0,
                               input logic [DW-1:0] id0, input logic ir1, input logic iw1,
                               input logic [AW-1:0] ia1, input logic [DW-1:0] id1,
                               input logic img, input logic imr, input logic [DW-1:0] ird);
    int cnt, winner;
    bit e0, e1, win_we, hit0, hit1;
    @(negedge clk);
    c0_req = ir0; c0_we = iw0; c0_addr = ia0; c0_wdata = id0;
    c1_req = ir1; c1_we = iw1; c1_addr = ia1; c1_wdata = id1;
    mem_gnt = img; mem_rvalid = imr; mem_rdata = ird;
    #1;
    cnt = tag_q.size();
    e0 = ir0 && (iw0 || cnt < 16);
    e1 = ir1 && (iw1 || cnt < 16);
    if (e0 && e1) winner = prio_m;
    else if (e0) winner = 0;
    else if (e1) winner = 1;
    else winner = -1;
    win_we = (winner == 1) ? iw1 : iw0;
    m_gnt0 = img && (winner == 0);
    m_gnt1 = img && (winner == 1);
    hit0 = imr && cnt > 0 && tag_q[0] == 0;
    hit1 = imr && cnt > 0 && tag_q[0] == 1;
    checkOutput("mem_req", DW'(mem_req), DW'(winner >= 0));
    checkOutput("mem_we", DW'(mem_we), DW'(winner >= 0 && win_we));
    checkOutput("mem_addr", DW'(mem_addr), (winner == 0) ? DW'(ia0) : (winner == 1) ? DW'(ia1) : '0);
    checkOutput("mem_wdata", mem_wdata, (winner == 0) ? id0 : (winner == 1) ? id1 : '0);
    checkOutput("c0_gnt", DW'(c0_gnt), DW'(m_gnt0));
    checkOutput("c1_gnt", DW'(c1_gnt), DW'(m_gnt1));
    checkOutput("c0_rvalid", DW'(c0_rvalid), DW'(hit0));
    checkOutput("c1_rvalid", DW'(c1_rvalid), DW'(hit1));
    checkOutput("c0_rdata", c0_rdata, ird);
    checkOutput("c1_rdata", c1_rdata, ird);
    checkOutput("outstanding", DW'(outstanding), DW'(cnt));
    checkOutput("resp_err", DW'(resp_err), DW'(err_m));
    if (imr) begin
      if (cnt > 0) void'(tag_q.pop_front());
      else err_m = 1'b1;
    end
    if (m_gnt0 || m_gnt1) begin
      if (!win_we) tag_q.push_back(winner);
      prio_m = 1 - winner;
    end
  endtask

  task automatic idle(input logic imr, input logic [DW-1:0] ird);
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0, imr, ird);
  endtask

  task automatic readC0(input logic [AW-1:0] ia);
    applyStimulus(1, 0, ia, '0, 0, 0, '0, '0, 1, 0, '0);
  endtask

  // Reset asserted off the clock edge while traffic is active; outputs must drop at once.
  task automatic asyncReset(input int offset);
    @(posedge clk);
    #(offset);
    rst = 1'b1;
    c0_req = 1'b1; c0_we = 1'b0; c1_req = 1'b1; c1_we = 1'b1;
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    #1;
    checkOutput("rst_mem_req", DW'(mem_req), '0);
    checkOutput("rst_c0_gnt", DW'(c0_gnt), '0);
    checkOutput("rst_c1_gnt", DW'(c1_gnt), '0);
    checkOutput("rst_c0_rvalid", DW'(c0_rvalid), '0);
    checkOutput("rst_c1_rvalid", DW'(c1_rvalid), '0);
    checkOutput("rst_outstanding", DW'(outstanding), '0);
    checkOutput("rst_resp_err", DW'(resp_err), '0);
    c0_req = 1'b0; c1_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    modelReset();
    idle(0, '0);

    // Single read routed back to client 0.
    readC0(32'h40);
    checkOutput("single_gnt", DW'(c0_gnt), DW'(1));
    idle(0, '0);
    checkOutput("single_outstanding", DW'(outstanding), DW'(1));
    repeat (3) idle(0, '0);
    idle(1, LINE_A);
    checkOutput("single_rv0", DW'(c0_rvalid), DW'(1));
    checkOutput("single_rv1", DW'(c1_rvalid), '0);
    checkOutput("single_rdata", c0_rdata, LINE_A);
    idle(0, '0);
    checkOutput("single_drained", DW'(outstanding), '0);

    // Contention from a fresh pointer: grants and responses alternate c0,c1,...
    asyncReset(3);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, AW'(i * 16), '0, 1, 0, AW'(32'h1000 + i * 16), '0, 1, 0, '0);
      checkOutput("fair_gnt0", DW'(c0_gnt), DW'(i % 2 == 0));
      checkOutput("fair_gnt1", DW'(c1_gnt), DW'(i % 2 == 1));
    end
    for (int i = 0; i < 6; i++) begin
      idle(1, {4{$urandom}});
      checkOutput("fair_rv0", DW'(c0_rvalid), DW'(i % 2 == 0));
      checkOutput("fair_rv1", DW'(c1_rvalid), DW'(i % 2 == 1));
    end

    // Write bypasses the tag FIFO.
    applyStimulus(0, 0, '0, '0, 1, 1, 32'h80, {16{8'hA5}}, 1, 0, '0);
    checkOutput("wr_mem_we", DW'(mem_we), DW'(1));
    checkOutput("wr_mem_addr", DW'(mem_addr), DW'(32'h80));
    checkOutput("wr_c1_gnt", DW'(c1_gnt), DW'(1));
    repeat (3) idle(0, '0);
    checkOutput("wr_outstanding", DW'(outstanding), '0);

    // Fill the FIFO, then confirm reads stall while writes still pass.
    for (int i = 0; i < 16; i++) readC0(AW'(32'h2000 + i * 16));
    readC0(32'h3000);
    checkOutput("full_outstanding", DW'(outstanding), DW'(16));
    checkOutput("full_c0_gnt", DW'(c0_gnt), '0);
    checkOutput("full_mem_req", DW'(mem_req), '0);
    applyStimulus(1, 0, 32'h3000, '0, 1, 1, 32'h600, {4{32'hDEADBEEF}}, 1, 0, '0);
    checkOutput("full_c0_blocked", DW'(c0_gnt), '0);
    checkOutput("full_c1_write", DW'(c1_gnt), DW'(1));
    applyStimulus(1, 0, 32'h3000, '0, 0, 0, '0, '0, 1, 1, LINE_A);
    checkOutput("full_pop_gnt", DW'(c0_gnt), '0);
    readC0(32'h3000);
    checkOutput("full_after_pop", DW'(outstanding), DW'(15));
    checkOutput("full_regrant", DW'(c0_gnt), DW'(1));
    repeat (16) idle(1, {4{$urandom}});

    // Push and pop in the same cycle.
    for (int i = 0; i < 3; i++) readC0(AW'(32'h4000 + i * 16));
    applyStimulus(0, 0, '0, '0, 1, 0, 32'h5000, '0, 1, 1, LINE_A);
    checkOutput("pp_rv0", DW'(c0_rvalid), DW'(1));
    checkOutput("pp_gnt1", DW'(c1_gnt), DW'(1));
    idle(1, LINE_A);
    checkOutput("pp_outstanding", DW'(outstanding), DW'(3));
    idle(1, LINE_A);
    idle(1, LINE_A);
    checkOutput("pp_tail", DW'(c1_rvalid), DW'(1));

    // Reset with reads in flight; late responses become spurious.
    readC0(32'h40);
    readC0(32'h80);
    asyncReset(3);
    idle(1, LINE_A);
    checkOutput("midrst_rv0", DW'(c0_rvalid | c1_rvalid), '0);
    idle(1, LINE_A);
    checkOutput("midrst_rv1", DW'(c0_rvalid | c1_rvalid), '0);
    idle(0, '0);
    checkOutput("midrst_err", DW'(resp_err), DW'(1));
    checkOutput("midrst_outstanding", DW'(outstanding), '0);

    // Random traffic; clients hold a request until it is granted.
    asyncReset(2);
    h0 = 1'b0; h1 = 1'b0;
    r0 = 0; w0 = 0; a0 = '0; d0 = '0; r1 = 0; w1 = 0; a1 = '0; d1 = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 500 == 499) begin
        asyncReset(int'($urandom_range(1, 4)));
        h0 = 1'b0; h1 = 1'b0;
      end
      if (!h0) begin
        r0 = 1'($urandom_range(0, 1)); w0 = ($urandom_range(0, 3) == 0);
        a0 = $urandom & ~32'hF; d0 = {4{$urandom}}; h0 = r0;
      end
      if (!h1) begin
        r1 = 1'($urandom_range(0, 1)); w1 = ($urandom_range(0, 3) == 0);
        a1 = $urandom & ~32'hF; d1 = {4{$urandom}}; h1 = r1;
      end
      mg = ($urandom_range(0, 3) != 0);
      if (tag_q.size() > 0) mr = ($urandom_range(0, 2) == 0);
      else mr = ($urandom_range(0, 49) == 0);
      rd = {4{$urandom}};
      applyStimulus(r0, w0, a0, d0, r1, w1, a1, d1, mg, mr, rd);
      if (m_gnt0) h0 = 1'b0;
      if (m_gnt1) h1 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-client arbiter sitting directly upstream of the line-wide memory model; feeds its req/we/addr/wdata port and consumes its rvalid/rdata.
- Client 0 is the instruction-side cache port and client 1 the data-side cache port. Both issue full-line (LINE_BYTES) reads/writes.
- Round-robin grant; in-order read-response routing via a tag FIFO, since memory returns reads in order at fixed latency with no ID.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_BYTES, 16, bytes per line; data buses are LINE_BYTES*8 bits.
- TAG_DEPTH, 16, max outstanding reads; power of 2, must be >= 10 (memory read latency) for back-to-back reads.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- c0_req, c1_req  input  1  client request.
- c0_we, c1_we  input  1  1=write line, 0=read line.
- c0_addr, c1_addr  input  ADDR_WIDTH  line address.
- c0_wdata, c1_wdata  input  LINE_BYTES*8  write data.
- c0_gnt, c1_gnt  output  1  request accepted this cycle.
- c0_rvalid, c1_rvalid  output  1  read data valid for that client.
- c0_rdata, c1_rdata  output  LINE_BYTES*8  read data.
- mem_req  output  1  request to memory.
- mem_we  output  1  write enable to memory.
- mem_addr  output  ADDR_WIDTH  address to memory.
- mem_wdata  output  LINE_BYTES*8  write data to memory.
- mem_gnt  input  1  memory accepted request.
- mem_rvalid  input  1  memory read data valid.
- mem_rdata  input  LINE_BYTES*8  memory read data.
- outstanding  output  $clog2(TAG_DEPTH)+1  reads in flight (FIFO count).
- resp_err  output  1  sticky: rvalid arrived with no read outstanding.

Behaviour:
- Reset: rst asserts asynchronously. Effects: prio pointer=0 (client 0 favoured), tag FIFO empty (rd/wr ptr=0, count=0), resp_err=0. While rst=1, mem_req, c0_gnt, c1_gnt, c0_rvalid and c1_rvalid are forced 0.
- Eligibility: cN_elig = cN_req && (cN_we || count < TAG_DEPTH). Writes are never blocked by FIFO state.
- Selection (combinational, zero-cycle):
  - Only one client eligible: that client is selected.
  - Both eligible: the client named by the prio pointer is selected.
- Memory-side drive: mem_req = c0_elig || c1_elig. mem_we, mem_addr and mem_wdata are muxed from the selected client; they are driven to 0 when nothing is selected.
- Grant: cN_gnt = selected==N && mem_gnt. A client holds req/we/addr/wdata stable until its gnt is seen.
- Prio pointer update: on any grant, at the next edge the pointer becomes the non-granted client. No update without a grant.
- Tag push: a granted read pushes the selected client ID (1 bit) into the tag FIFO at the clock edge.
- Tag pop and response routing:
  - mem_rvalid pops the FIFO head at the edge.
  - cN_rvalid = mem_rvalid && !empty && head==N (combinational).
  - c0_rdata = c1_rdata = mem_rdata (broadcast; rvalid qualifies).
  - Response latency through the block: 0 cycles.
- Simultaneous push and pop: count unchanged, both pointers advance. A push while full cannot occur, because eligibility already blocks it.
- Writes: no tag is pushed and no response is expected.
- Pointer wrap: rd/wr ptr wrap modulo TAG_DEPTH.
- Spurious response: mem_rvalid while the FIFO is empty gives no rvalid to either client. No pop occurs, and resp_err sets and stays 1 until rst. This covers responses from reads in flight across an arbiter reset.
- Reset mid-operation: all tags are lost; subsequent memory responses are handled as spurious (above).
- outstanding always equals the FIFO count. Registered state updates on the rising clk edge only.

Test Plan:
- Single read: c0 read addr 0x40, mem_gnt=1. Required: c0_gnt=1 same cycle, outstanding=1. When mem_rvalid returns rdata 0x00112233…, c0_rvalid=1, c1_rvalid=0, outstanding=0.
- Contention fairness: c0 and c1 both hold reads every cycle for 6 cycles, mem_gnt=1. Required: grants alternate c0,c1,c0,c1,c0,c1. The 6 responses route in the same order.
- Write bypass: c1 write addr 0x80, wdata 0xA5 repeated. Required: mem_we=1, mem_addr=0x80, c1_gnt=1, outstanding unchanged at 0, no rvalid ever.
- FIFO full: hold mem_rvalid=0 and issue 16 c0 reads. Required: outstanding=16. On the 17th cycle, the c0 read gets gnt=0 and mem_req=0, while a concurrent c1 write is still granted. One mem_rvalid then drops outstanding to 15 and c0 is re-granted.
- Simultaneous push/pop: outstanding=3, a c1 read is granted in the same cycle mem_rvalid returns a c0 tag. Required: c0_rvalid=1, outstanding stays 3, the new tail is c1.
- Reset mid-flight: 2 reads outstanding, pulse rst asynchronously (not clock-aligned), then 2 mem_rvalid pulses. Required: outputs 0 immediately on rst, no client rvalid afterwards, resp_err=1, outstanding=0.
